tx_flags_controller: RTL and testbench

TX_FLAGS_CONTROLLER -- requirements
Module: tx_flags_controller

---
 rtl/tx_flags_controller.sv | 164 ++++++++++++++++
 tb/tb_tx_flags_controller.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_flags_controller.sv
// ---------------------------------------------------------------------------
// tx_flags_controller
//
// Packet transmit controller with per-destination flow-control flags.
// A core requests to send one packet of PACKET_WORDS words to a destination.
// The request is granted only when that destination is not already awaiting
// a ready-to-receive (rtr) return. Once granted, the destination's flag is
// set and the packet is streamed word by word onto the link. Each remote rtr
// clears the flag of its destination again.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   tx_request      core wants to send a packet (held until tx_grant)
//   tx_address      destination of the requested packet
//   tx_data         current packet word from the core
//   word_read       core advances to its next word this cycle
//   tx_grant        one-cycle pulse: request accepted
//   tx_blocked      request pending to a destination still awaiting rtr
//   link_valid      link word valid
//   link_last       final word of the packet
//   link_address    destination of the link word
//   link_data       link word
//   link_ready      link accepts the word this cycle
//   rtr_valid       remote ready-to-receive return
//   rtr_address     destination the rtr refers to
//   busy            packet in flight
//   flags           per-destination outstanding flags (1 = awaiting rtr)
//   rtr_error       one-cycle pulse: rtr for a destination that was not
//                   awaiting one
// ---------------------------------------------------------------------------
module tx_flags_controller #(
    parameter int ADDR_WIDTH_RF = 1,
    parameter int DATA_WIDTH    = 32,
    parameter int PACKET_WORDS  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tx_request,
    input  logic [ADDR_WIDTH_RF-1:0]        tx_address,
    input  logic [DATA_WIDTH-1:0]           tx_data,
    output logic                            word_read,
    output logic                            tx_grant,
    output logic                            tx_blocked,
    output logic                            link_valid,
    output logic                            link_last,
    output logic [ADDR_WIDTH_RF-1:0]        link_address,
    output logic [DATA_WIDTH-1:0]           link_data,
    input  logic                            link_ready,
    input  logic                            rtr_valid,
    input  logic [ADDR_WIDTH_RF-1:0]        rtr_address,
    output logic                            busy,
    output logic [(2**ADDR_WIDTH_RF)-1:0]   flags,
    output logic                            rtr_error
);

    localparam int NDEST = 2 ** ADDR_WIDTH_RF;
    // A one-word packet still needs a 1-bit counter.
    localparam int CNT_W = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACKET_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH_RF-1:0] dest_q, dest_d;
    logic [NDEST-1:0]         flags_q, flags_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dest_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dest_d       = dest_q;
        flags_d      = flags_q;
        tx_grant     = 1'b0;
        tx_blocked   = 1'b0;
        link_valid   = 1'b0;
        link_last    = 1'b0;
        link_address = '0;
        link_data    = '0;
        word_read    = 1'b0;
        rtr_error    = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_request) begin
                    if (flags_q[tx_address]) begin
                        tx_blocked = 1'b1;
                    end else begin
                        tx_grant = 1'b1;
                        dest_d   = tx_address;
                        cnt_d    = '0;
                        state_d  = SEND;
                    end
                end
            end
            SEND: begin
                // Core word is passed straight through; the core only
                // advances when the link actually takes it.
                link_valid   = 1'b1;
                link_address = dest_q;
                link_data    = tx_data;
                link_last    = (cnt_q == CNT_LAST);
                if (link_ready) begin
                    word_read = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rtr_valid) begin
            if (flags_q[rtr_address]) begin
                flags_d[rtr_address] = 1'b0;
            end else begin
                rtr_error = 1'b1;
            end
        end

        // Applied after the rtr clear so that a grant and an rtr to the
        // same destination in one cycle leave the flag set.
        if (tx_grant) begin
            flags_d[tx_address] = 1'b1;
        end

        // All outputs are forced low while reset is asserted.
        if (reset) begin
            tx_grant     = 1'b0;
            tx_blocked   = 1'b0;
            link_valid   = 1'b0;
            link_last    = 1'b0;
            link_address = '0;
            link_data    = '0;
            word_read    = 1'b0;
            rtr_error    = 1'b0;
        end
    end

    assign busy  = (state_q == SEND) && !reset;
    assign flags = reset ? '0 : flags_q;

endmodule

// File: tb/tb_tx_flags_controller.sv
module tb_tx_flags_controller;

    localparam int AW = 1;
    localparam int DW = 32;
    localparam int PW = 4;

    logic            clk;
    logic            reset;
    logic            tx_request;
    logic [AW-1:0]   tx_address;
    logic [DW-1:0]   tx_data;
    logic            word_read;
    logic            tx_grant;
    logic            tx_blocked;
    logic            link_valid;
    logic            link_last;
    logic [AW-1:0]   link_address;
    logic [DW-1:0]   link_data;
    logic            link_ready;
    logic            rtr_valid;
    logic [AW-1:0]   rtr_address;
    logic            busy;
    logic [(2**AW)-1:0] flags;
    logic            rtr_error;

    tx_flags_controller #(
        .ADDR_WIDTH_RF(AW),
        .DATA_WIDTH   (DW),
        .PACKET_WORDS (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_request  (tx_request),
        .tx_address  (tx_address),
        .tx_data     (tx_data),
        .word_read   (word_read),
        .tx_grant    (tx_grant),
        .tx_blocked  (tx_blocked),
        .link_valid  (link_valid),
        .link_last   (link_last),
        .link_address(link_address),
        .link_data   (link_data),
        .link_ready  (link_ready),
        .rtr_valid   (rtr_valid),
        .rtr_address (rtr_address),
        .busy        (busy),
        .flags       (flags),
        .rtr_error   (rtr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rd_cnt  = 0;

    // Core model: word i of the current packet is base + i.
    logic [DW-1:0] base;
    logic [DW-1:0] widx;
    assign tx_data = base + widx;

    always @(posedge clk) begin
        if (reset)          widx <= '0;
        else if (tx_grant)  widx <= '0;
        else if (word_read) widx <= widx + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input logic [AW-1:0] a, input logic [DW-1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.addr = a;
            e.data = b + DW'(i);
            e.last = (i == PW - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    // Monitor: every link handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (word_read === 1'b1) begin
            rd_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got data %0h expected none", link_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("link_data", 64'(link_data), 64'(mon_e.data));
                chk("link_address", 64'(link_address), 64'(mon_e.addr));
                chk("link_last", 64'(link_last), 64'(mon_e.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        bit pat[7];
        int r0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset with request and rtr both asserted: reset wins.
        reset = 1'b1; tx_request = 1'b1; tx_address = '0;
        rtr_valid = 1'b1; rtr_address = '0; link_ready = 1'b1; base = '0;
        neg;
        chk("rst_grant", 64'(tx_grant), 64'd0);
        chk("rst_rtr_error", 64'(rtr_error), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_link_valid", 64'(link_valid), 64'd0);
        cyc;
        neg;
        chk("rst2_flags", 64'(flags), 64'd0);
        chk("rst2_busy", 64'(busy), 64'd0);
        chk("rst2_word_read", 64'(word_read), 64'd0);
        chk("rst2_link_data", 64'(link_data), 64'd0);
        chk("rst2_blocked", 64'(tx_blocked), 64'd0);
        cyc;
        reset = 1'b0; tx_request = 1'b0; rtr_valid = 1'b0;
        neg;
        chk("post_rst_flags", 64'(flags), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_link_valid", 64'(link_valid), 64'd0);

        // Basic packet to destination 1.
        cyc;
        base = 32'hA000_0000; tx_request = 1'b1; tx_address = 1'b1;
        push_pkt(1'b1, base, PW);
        neg;
        chk("p1_grant", 64'(tx_grant), 64'd1);
        chk("p1_blocked", 64'(tx_blocked), 64'd0);
        cyc;
        tx_request = 1'b0;
        for (int i = 0; i < PW; i++) begin
            neg;
            chk("p1_busy", 64'(busy), 64'd1);
            chk("p1_link_valid", 64'(link_valid), 64'd1);
            chk("p1_flags", 64'(flags), 64'd2);
            chk("p1_no_grant", 64'(tx_grant), 64'd0);
            cyc;
        end
        neg;
        chk("p1_done_busy", 64'(busy), 64'd0);
        chk("p1_done_link_valid", 64'(link_valid), 64'd0);
        chk("p1_done_flags", 64'(flags), 64'd2);

        // Blocked request, released by rtr.
        cyc;
        tx_request = 1'b1; tx_address = 1'b1;
        neg;
        chk("blk_blocked", 64'(tx_blocked), 64'd1);
        chk("blk_grant", 64'(tx_grant), 64'd0);
        cyc;
        neg;
        chk("blk2_blocked", 64'(tx_blocked), 64'd1);
        chk("blk2_busy", 64'(busy), 64'd0);
        cyc;
        rtr_valid = 1'b1; rtr_address = 1'b1;
        neg;
        chk("blk_rtr_blocked", 64'(tx_blocked), 64'd1);
        chk("blk_rtr_error", 64'(rtr_error), 64'd0);
        cyc;
        rtr_valid = 1'b0; base = 32'hB000_0000;
        push_pkt(1'b1, base, PW);
        neg;
        chk("unblk_flags", 64'(flags), 64'd0);
        chk("unblk_grant", 64'(tx_grant), 64'd1);
        cyc;
        tx_request = 1'b0;

        // Back-pressure on the link.
        r0 = rd_cnt;
        for (int k = 0; k < 7; k++) begin
            link_ready = pat[k];
            neg;
            chk("bp_link_valid", 64'(link_valid), 64'd1);
            cyc;
        end
        link_ready = 1'b1;
        neg;
        chk("bp_busy", 64'(busy), 64'd0);
        chk("bp_read_count", 64'(rd_cnt - r0), 64'd4);

        // Spurious rtr.
        cyc;
        rtr_valid = 1'b1; rtr_address = 1'b1;
        neg;
        chk("rtr1_error", 64'(rtr_error), 64'd0);
        cyc;
        rtr_address = 1'b0;
        neg;
        chk("rtr0_flags", 64'(flags), 64'd0);
        chk("rtr0_error", 64'(rtr_error), 64'd1);
        cyc;
        rtr_valid = 1'b0;
        neg;
        chk("rtr0_error_pulse", 64'(rtr_error), 64'd0);
        chk("rtr0_flags_unch", 64'(flags), 64'd0);

        // Grant and rtr to the same destination in one cycle.
        cyc;
        base = 32'hC000_0000; tx_request = 1'b1; tx_address = 1'b0;
        rtr_valid = 1'b1; rtr_address = 1'b0;
        push_pkt(1'b0, base, PW);
        neg;
        chk("same_grant", 64'(tx_grant), 64'd1);
        chk("same_rtr_error", 64'(rtr_error), 64'd1);
        cyc;
        tx_request = 1'b0; rtr_valid = 1'b0;
        neg;
        chk("same_flags", 64'(flags), 64'd1);
        repeat (PW) cyc;
        neg;
        chk("same_done_busy", 64'(busy), 64'd0);
        rtr_valid = 1'b0;
        cyc;
        rtr_valid = 1'b1; rtr_address = 1'b0;
        neg;
        chk("clr0_error", 64'(rtr_error), 64'd0);
        cyc;
        rtr_valid = 1'b0;
        neg;
        chk("clr0_flags", 64'(flags), 64'd0);

        // Set flag 1, then grant 0 with rtr 1 in the same cycle.
        cyc;
        base = 32'hD000_0000; tx_request = 1'b1; tx_address = 1'b1;
        push_pkt(1'b1, base, PW);
        neg;
        chk("d_grant", 64'(tx_grant), 64'd1);
        cyc;
        tx_request = 1'b0;
        repeat (PW) cyc;
        neg;
        chk("d_flags", 64'(flags), 64'd2);
        cyc;
        base = 32'hE000_0000; tx_request = 1'b1; tx_address = 1'b0;
        rtr_valid = 1'b1; rtr_address = 1'b1;
        push_pkt(1'b0, base, PW);
        neg;
        chk("diff_grant", 64'(tx_grant), 64'd1);
        chk("diff_rtr_error", 64'(rtr_error), 64'd0);
        cyc;
        tx_request = 1'b0; rtr_valid = 1'b0;
        neg;
        chk("diff_flags", 64'(flags), 64'd1);
        repeat (PW) cyc;
        neg;
        chk("diff_done_busy", 64'(busy), 64'd0);

        // Reset on the second word of a packet.
        cyc;
        base = 32'hF000_0000; tx_request = 1'b1; tx_address = 1'b1;
        push_pkt(1'b1, base, 1);
        neg;
        chk("f_grant", 64'(tx_grant), 64'd1);
        cyc;
        tx_request = 1'b0;
        neg;
        chk("f_word0_valid", 64'(link_valid), 64'd1);
        cyc;
        reset = 1'b1;
        neg;
        chk("f_rst_link_valid", 64'(link_valid), 64'd0);
        chk("f_rst_word_read", 64'(word_read), 64'd0);
        cyc;
        reset = 1'b0;
        base = 32'h1234_0000; tx_request = 1'b1; tx_address = 1'b1;
        push_pkt(1'b1, base, PW);
        neg;
        chk("after_rst_link_valid", 64'(link_valid), 64'd0);
        chk("after_rst_busy", 64'(busy), 64'd0);
        chk("after_rst_flags", 64'(flags), 64'd0);
        chk("after_rst_grant", 64'(tx_grant), 64'd1);
        cyc;
        tx_request = 1'b0;
        repeat (PW) cyc;
        neg;
        chk("g_done_busy", 64'(busy), 64'd0);
        chk("g_done_flags", 64'(flags), 64'd2);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
